// File: rtl/mem_pkg.sv
// ============================================================================
// Module  : mem_pkg
// Purpose : Shared widths, default depth and FSM state encoding for the
//           memory port master and anything that talks to it.
// Contents: ADDR_W, DATA_W, WDATA_W, MEM_DEPTH_DEF, state_t
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  localparam int ADDR_W        = 8;    // word address width
  localparam int DATA_W        = 20;   // memory read data width
  localparam int WDATA_W       = 8;    // store data width (memory zero-extends)
  localparam int MEM_DEPTH_DEF = 201;  // default number of valid words

  // Explicit 3-bit encoding so the state register width is fixed.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    WRB  = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_master_if.sv
// ============================================================================
// Module  : mem_port_master_if
// Purpose : Bundles the datapath request/response handshake and the memory
//           port of mem_port_master.
// Ports   : master modport - seen by mem_port_master (drives req_ready,
//                            rsp_*, mem_addr, mem_w, mem_in)
//           slave modport  - seen by the datapath/memory side
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_master_if;
  import mem_pkg::*;

  // datapath request
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [WDATA_W-1:0] req_wdata;

  // datapath response
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_rdata;
  logic               rsp_err;

  // memory port (combinational read, write on rising edge)
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_w;
  logic [WDATA_W-1:0] mem_in;
  logic [DATA_W-1:0]  mem_out;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_w, mem_in
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, mem_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_w, mem_in
  );

endinterface

`default_nettype wire

// File: rtl/mem_port_master.sv
// ============================================================================
// Module  : mem_port_master
// Purpose : Turns single load/store requests from a datapath into accesses on
//           a simple combinational-read memory. One request outstanding at a
//           time; illegal addresses are answered with an error response and
//           never touch memory.
// Params  : MEM_DEPTH   - number of valid word addresses (0..MEM_DEPTH-1)
//           ALIGN_CHECK - 1: addresses with addr[1:0] != 0 are rejected
// Ports   : clk - clock, rising edge
//           rst - synchronous active-high reset
//           bus - mem_port_master_if.master (request, response, memory port)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_master
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_master_if.master bus
);

  // Depth compared with one extra bit so a depth of 256 still fits.
  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t             r_state;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;
  logic [ADDR_W-1:0]  r_mem_addr;   // doubles as the latched request address
  logic               r_mem_w;
  logic [WDATA_W-1:0] r_mem_in;     // doubles as the latched store data

  logic w_range_err;
  logic w_align_err;
  logic w_err;
  logic w_handshake;

  assign w_range_err = ({1'b0, bus.req_addr} >= c_DEPTH);
  assign w_align_err = (ALIGN_CHECK != 0) && (bus.req_addr[1:0] != 2'b00);
  assign w_err       = w_range_err | w_align_err;
  assign w_handshake = bus.req_valid & r_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_w     <= 1'b0;
      r_mem_in    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_handshake) begin
            r_req_ready <= 1'b0;
            if (w_err) begin
              // Rejected: straight to a response, memory untouched.
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else if (bus.req_write) begin
              r_state    <= WR;
              r_mem_addr <= bus.req_addr;
              r_mem_w    <= 1'b1;
              r_mem_in   <= bus.req_wdata;
            end else begin
              r_state    <= RD;
              r_mem_addr <= bus.req_addr;
            end
          end
        end

        RD: begin
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= bus.mem_out;
          r_mem_addr  <= '0;
        end

        WR: begin
          // Write pulse lasts exactly this one cycle.
          r_state  <= WRB;
          r_mem_w  <= 1'b0;
          r_mem_in <= '0;
        end

        WRB: begin
          // Memory now holds the stored word; return it as readback.
          r_state     <= RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= bus.mem_out;
          r_mem_addr  <= '0;
        end

        RESP: begin
          // No bypass: a new request is only taken in the following IDLE.
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_w     <= 1'b0;
          r_mem_in    <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_in    = r_mem_in;
  // The memory samples mem_w on the same edge that samples rst, so the
  // write enable is masked by rst directly; otherwise a store caught by
  // reset in WR would still land in memory.
  assign bus.mem_w     = r_mem_w & ~rst;

endmodule

`default_nettype wire

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 201, number of valid word locations (addresses 0..MEM_DEPTH-1).
REQ-002 SHALL have parameter ALIGN_CHECK, default 1; 1 = reject addresses with addr[1:0] != 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  1  datapath request present.
REQ-006 req_ready  out  1  block accepts a request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  8  word address.
REQ-009 req_wdata  in  8  store data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  datapath consumes response.
REQ-012 rsp_rdata  out  20  load data, or store readback.
REQ-013 rsp_err  out  1  request rejected; no memory access made.
REQ-014 mem_addr  out  8  memory address; memory read is combinational.
REQ-015 mem_w  out  1  memory write enable, sampled by memory on rising edge.
REQ-016 mem_in  out  8  memory write data; memory zero-extends to 20 bits.
REQ-017 mem_out  in  20  memory combinational read data.

Function
REQ-018 SHALL implement FSM states IDLE, RD, WR, WRB, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready at a rising edge.
REQ-020 On handshake, addr/write/wdata SHALL be latched; mem_addr SHALL drive the latched address in RD, WR and WRB, and 0 in IDLE and RESP.
REQ-021 Error = req_addr >= MEM_DEPTH, or ALIGN_CHECK=1 and req_addr[1:0] != 0; error handshake SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0, mem_w never asserted.
REQ-022 Load: IDLE->RD->RESP; mem_out SHALL be registered into rsp_rdata at the RD->RESP edge; rsp_valid first high 2 cycles after handshake.
REQ-023 Store: IDLE->WR->WRB->RESP; mem_w=1 and mem_in=latched wdata for exactly the WR cycle; mem_out captured at WRB->RESP edge; rsp_valid first high 3 cycles after handshake.
REQ-024 mem_w SHALL be 0 in every state except WR; mem_in SHALL be 0 outside WR.
REQ-025 rsp_valid SHALL be 1 exactly in RESP; rsp_rdata/rsp_err SHALL hold stable until rsp_valid & rsp_ready, then RESP->IDLE.
REQ-026 A req_valid present while in RESP SHALL NOT be accepted in that cycle, even with rsp_ready=1; earliest acceptance is the following IDLE cycle (one request outstanding, no bypass).
REQ-027 Request inputs changing after handshake SHALL NOT affect the in-flight transaction.
REQ-028 Address MEM_DEPTH-1 (200) SHALL be legal when ALIGN_CHECK=0; 200 with ALIGN_CHECK=1 is legal (aligned); 201..255 always error.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_w=0, mem_addr=0, mem_in=0, req_ready=1 after that edge.
REQ-030 rst during WR SHALL deassert mem_w from that edge; no store may complete once rst is sampled. Pending response discarded.
REQ-031 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-032 Shared package mem_pkg SHALL hold ADDR_W=8, DATA_W=20, WDATA_W=8, default MEM_DEPTH and the FSM state enum.
REQ-033 Single flat module; no sub-module; address check is combinational logic inside it.

Verification (bench pairs block with behavioural 201x20 memory, address 8 preloaded 20'h12345)
REQ-034 Load addr 8 -> rsp_valid 2 cycles after handshake, rsp_rdata=20'h12345, rsp_err=0, mem_w never 1.
REQ-035 Store addr 4 wdata 8'hA5 -> mem_w high exactly one cycle, rsp_rdata=20'h000A5 after 3 cycles; subsequent load addr 4 returns 20'h000A5.
REQ-036 Load addr 6 (ALIGN_CHECK=1) and load addr 204 -> rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after handshake, no memory write.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0; new req_valid accepted only in IDLE cycle after rsp_ready=1.
REQ-038 rst asserted during WR of store addr 12 wdata 8'h3C -> addr 12 unchanged, all outputs at reset values next cycle.
